// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions.
//   alu_opcode_e  : 10-bit {funct3, opcode[6:0]} encoding used on the alu opcode bus
//   FUNCT7_MULDIV : funct7 value selecting the M extension
//   ctrl_state_e  : issue controller states
//   is_div_op()   : true for the divide/remainder family (64-bit and W forms)
package riscv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [9:0] {
        OP_ADDI  = 10'h013,
        OP_ADD   = 10'h033,
        OP_DIV   = 10'h233,
        OP_DIVU  = 10'h2b3,
        OP_REM   = 10'h333,
        OP_REMU  = 10'h3b3,
        OP_DIVW  = 10'h23b,
        OP_DIVUW = 10'h2bb,
        OP_REMW  = 10'h33b,
        OP_REMUW = 10'h3bb
    } alu_opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    function automatic logic is_div_op(input logic [9:0] opcode, input logic [6:0] funct7);
        logic hit;
        hit = 1'b0;
        case (opcode)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: hit = 1'b1;
            default:                              hit = 1'b0;
        endcase
        return hit && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode <-> execute bus of the alu issue controller.
//   in_*   : instruction from decode, in_ready back-pressure
//   is_flush : pipeline flush
//   fwd_*  : latched single-cycle instruction for the alu
//   div_*  : divide/remainder writeback
//   busy   : controller not idle
// modport master = decode/writeback side, slave = controller.
interface alu_issue_ctrl_if #(parameter int XLEN = 64);
    logic            is_flush;
    logic            in_valid;
    logic            in_ready;
    logic [9:0]      in_opcode;
    logic [6:0]      in_funct7;
    logic [4:0]      in_rd;
    logic [31:0]     in_pc;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic            fwd_valid;
    logic [9:0]      fwd_opcode;
    logic [4:0]      fwd_rd;
    logic [31:0]     fwd_pc;
    logic [XLEN-1:0] fwd_rs1_val;
    logic [XLEN-1:0] fwd_rs2_val;
    logic            div_valid;
    logic [XLEN-1:0] div_data;
    logic [4:0]      div_rd;
    logic            div_wr_en;
    logic            busy;

    modport master (
        output is_flush, in_valid, in_opcode, in_funct7, in_rd, in_pc, in_rs1_val, in_rs2_val,
        input  in_ready, fwd_valid, fwd_opcode, fwd_rd, fwd_pc, fwd_rs1_val, fwd_rs2_val,
        input  div_valid, div_data, div_rd, div_wr_en, busy
    );

    modport slave (
        input  is_flush, in_valid, in_opcode, in_funct7, in_rd, in_pc, in_rs1_val, in_rs2_val,
        output in_ready, fwd_valid, fwd_opcode, fwd_rd, fwd_pc, fwd_rs1_val, fwd_rs2_val,
        output div_valid, div_data, div_rd, div_wr_en, busy
    );
endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   start/is_w : load operands; is_w runs ITER32 steps on dividend[31:0]
//   kill       : abandon the current division (counter cleared)
//   busy       : steps remaining; last = the final step happens this cycle
//   quotient/remainder : valid once busy drops, held until the next start
module serial_divider #(
    parameter int XLEN   = 64,
    parameter int ITER64 = 64,
    parameter int ITER32 = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kill,
    input  logic            start,
    input  logic            is_w,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            last,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CNT_W = $clog2(ITER64 + 1);

    logic [CNT_W-1:0] count_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  dvs_r;
    logic [XLEN:0]    rem_shift_s;
    logic [XLEN:0]    diff_s;
    logic             ge_s;

    // One shift-subtract trial step; the dividend is consumed MSB-first from quo_r.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        ge_s        = (rem_shift_s >= {1'b0, dvs_r});
    end

    // Iteration counter and datapath registers.
    always_ff @(posedge clk) begin
        if (reset || kill) begin
            count_r <= {CNT_W{1'b0}};
            quo_r   <= {XLEN{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            dvs_r   <= {XLEN{1'b0}};
        end else if (start) begin
            count_r <= is_w ? CNT_W'(ITER32) : CNT_W'(ITER64);
            // W operands are parked in the top half so the MSB-first walk starts at bit 31.
            quo_r   <= is_w ? (dividend << (XLEN - 32)) : dividend;
            rem_r   <= {XLEN{1'b0}};
            dvs_r   <= divisor;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
            quo_r   <= {quo_r[XLEN-2:0], ge_s};
            rem_r   <= ge_s ? diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
        end
    end

    assign busy      = (count_r != {CNT_W{1'b0}});
    assign last      = (count_r == CNT_W'(1));
    assign quotient  = quo_r;
    assign remainder = rem_r;
endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller between decode and the single-cycle alu.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_issue_ctrl_if.slave (decode input, alu forward, divide writeback)
// Single-cycle ops are forwarded with one register stage; the divide family is
// run on serial_divider with decode stalled (in_ready low) until the result is out.
module alu_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DIV_ITER64 = 64,
    parameter int DIV_ITER32 = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_ctrl_if.slave    bus
);
    ctrl_state_e     state_r, state_next_s;
    logic            accept_s, div_op_s, corner_s, start_s;
    logic            op_signed_s, op_rem_s, op_w_s, neg_a_s, neg_b_s, div0_s, ovf_s;
    logic [XLEN-1:0] a_ext_s, b_ext_s, mag_a_s, mag_b_s, most_neg_s, corner_res_s;
    logic [XLEN-1:0] raw_s, result_s, div_quo_s, div_rem_s;
    logic            div_busy_s, div_last_s;

    logic            rem_op_r, w_op_r, q_neg_r, r_neg_r, corner_r;
    logic [XLEN-1:0] corner_res_r;
    logic [4:0]      rd_r;

    logic            ready_r, busy_r, fwd_valid_r, div_valid_r, div_wr_en_r;
    logic [9:0]      fwd_opcode_r;
    logic [4:0]      fwd_rd_r, div_rd_r;
    logic [31:0]     fwd_pc_r;
    logic [XLEN-1:0] fwd_rs1_r, fwd_rs2_r, div_data_r;

    // Decode, operand extension and divide corner-case detection.
    always_comb begin
        div_op_s    = is_div_op(bus.in_opcode, bus.in_funct7);
        accept_s    = bus.in_valid && bus.in_ready && !bus.is_flush;
        // funct3 = {1, rem, unsigned}; opcode bit 3 separates OP-32 (W) from OP.
        op_signed_s = !bus.in_opcode[7];
        op_rem_s    = bus.in_opcode[8];
        op_w_s      = bus.in_opcode[3];
        if (op_w_s) begin
            a_ext_s    = {{(XLEN-32){op_signed_s && bus.in_rs1_val[31]}}, bus.in_rs1_val[31:0]};
            b_ext_s    = {{(XLEN-32){op_signed_s && bus.in_rs2_val[31]}}, bus.in_rs2_val[31:0]};
            most_neg_s = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            a_ext_s    = bus.in_rs1_val;
            b_ext_s    = bus.in_rs2_val;
            most_neg_s = {1'b1, {(XLEN-1){1'b0}}};
        end
        neg_a_s  = op_signed_s && a_ext_s[XLEN-1];
        neg_b_s  = op_signed_s && b_ext_s[XLEN-1];
        mag_a_s  = neg_a_s ? -a_ext_s : a_ext_s;
        mag_b_s  = neg_b_s ? -b_ext_s : b_ext_s;
        div0_s   = (b_ext_s == {XLEN{1'b0}});
        ovf_s    = op_signed_s && !div0_s && (b_ext_s == {XLEN{1'b1}}) && (a_ext_s == most_neg_s);
        corner_s = div0_s || ovf_s;
        if (div0_s) begin
            corner_res_s = op_rem_s ? a_ext_s : {XLEN{1'b1}};
        end else begin
            corner_res_s = op_rem_s ? {XLEN{1'b0}} : a_ext_s;
        end
        start_s = accept_s && div_op_s && !corner_s;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (bus.is_flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = (accept_s && div_op_s) ? (corner_s ? DONE : RUN) : IDLE;
                RUN:     state_next_s = div_last_s ? DONE : RUN;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-divide context captured at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_op_r     <= 1'b0;
            w_op_r       <= 1'b0;
            q_neg_r      <= 1'b0;
            r_neg_r      <= 1'b0;
            corner_r     <= 1'b0;
            corner_res_r <= {XLEN{1'b0}};
            rd_r         <= 5'd0;
        end else if (accept_s && div_op_s) begin
            rem_op_r     <= op_rem_s;
            w_op_r       <= op_w_s;
            q_neg_r      <= neg_a_s ^ neg_b_s;
            r_neg_r      <= neg_a_s;
            corner_r     <= corner_s;
            corner_res_r <= corner_res_s;
            rd_r         <= bus.in_rd;
        end
    end

    serial_divider #(
        .XLEN   (XLEN),
        .ITER64 (DIV_ITER64),
        .ITER32 (DIV_ITER32)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .kill      (bus.is_flush),
        .start     (start_s),
        .is_w      (op_w_s),
        .dividend  (mag_a_s),
        .divisor   (mag_b_s),
        .busy      (div_busy_s),
        .last      (div_last_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Sign fix-up: quotient negated on sign mismatch, remainder follows the dividend.
    always_comb begin
        if (corner_r) begin
            raw_s = corner_res_r;
        end else if (rem_op_r) begin
            raw_s = r_neg_r ? -div_rem_s : div_rem_s;
        end else begin
            raw_s = q_neg_r ? -div_quo_s : div_quo_s;
        end
        if (w_op_r) begin
            result_s = {{(XLEN-32){raw_s[31]}}, raw_s[31:0]};
        end else begin
            result_s = raw_s;
        end
    end

    // Registered outputs: forward pulse, divide writeback pulse, ready/busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            fwd_valid_r  <= 1'b0;
            fwd_opcode_r <= 10'd0;
            fwd_rd_r     <= 5'd0;
            fwd_pc_r     <= 32'd0;
            fwd_rs1_r    <= {XLEN{1'b0}};
            fwd_rs2_r    <= {XLEN{1'b0}};
            div_valid_r  <= 1'b0;
            div_data_r   <= {XLEN{1'b0}};
            div_rd_r     <= 5'd0;
            div_wr_en_r  <= 1'b0;
        end else begin
            ready_r     <= (state_next_s == IDLE);
            busy_r      <= (state_next_s != IDLE);
            fwd_valid_r <= 1'b0;
            div_valid_r <= 1'b0;
            div_wr_en_r <= 1'b0;
            if (accept_s && !div_op_s) begin
                fwd_valid_r  <= 1'b1;
                fwd_opcode_r <= bus.in_opcode;
                fwd_rd_r     <= bus.in_rd;
                fwd_pc_r     <= bus.in_pc;
                fwd_rs1_r    <= bus.in_rs1_val;
                fwd_rs2_r    <= bus.in_rs2_val;
            end
            if (!bus.is_flush && (state_r == DONE)) begin
                div_valid_r <= 1'b1;
                div_data_r  <= result_s;
                div_rd_r    <= rd_r;
                div_wr_en_r <= (rd_r != 5'd0);
            end
        end
    end

    assign bus.in_ready    = ready_r;
    assign bus.busy        = busy_r;
    assign bus.fwd_valid   = fwd_valid_r;
    assign bus.fwd_opcode  = fwd_opcode_r;
    assign bus.fwd_rd      = fwd_rd_r;
    assign bus.fwd_pc      = fwd_pc_r;
    assign bus.fwd_rs1_val = fwd_rs1_r;
    assign bus.fwd_rs2_val = fwd_rs2_r;
    assign bus.div_valid   = div_valid_r;
    assign bus.div_data    = div_data_r;
    assign bus.div_rd      = div_rd_r;
    assign bus.div_wr_en   = div_wr_en_r;

    logic unused_s;
    assign unused_s = div_busy_s;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_issue_ctrl_if #(.XLEN(64)) bus ();

    alu_issue_ctrl #(.XLEN(64), .DIV_ITER64(64), .DIV_ITER32(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for exactly one edge (edge T); returns in cycle T+1.
    task automatic issue(input logic [9:0] opc, input logic [6:0] f7, input logic [4:0] rd,
                         input logic [63:0] rs1, input logic [63:0] rs2);
        bus.in_valid   = 1'b1;
        bus.in_opcode  = opc;
        bus.in_funct7  = f7;
        bus.in_rd      = rd;
        bus.in_pc      = 32'h0000_1000 + {27'd0, rd};
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        tick();
        bus.in_valid   = 1'b0;
    endtask

    // Issue a divide and expect div_valid exactly in cycle T+lat.
    task automatic run_div(input string tag, input logic [9:0] opc, input logic [4:0] rd,
                           input logic [63:0] rs1, input logic [63:0] rs2, input int lat,
                           input logic [63:0] exp_data, input logic exp_wr);
        int bad;
        bad = 0;
        issue(opc, 7'h01, rd, rs1, rs2);
        for (int i = 1; i < lat; i++) begin
            if (bus.in_ready !== 1'b0 || bus.div_valid !== 1'b0 || bus.fwd_valid !== 1'b0) bad++;
            tick();
        end
        chk({tag, "_stall"}, 64'(bad), 64'd0);
        chk({tag, "_valid"}, {63'd0, bus.div_valid}, 64'd1);
        chk({tag, "_data"},  bus.div_data, exp_data);
        chk({tag, "_rd"},    {59'd0, bus.div_rd}, {59'd0, rd});
        chk({tag, "_wr_en"}, {63'd0, bus.div_wr_en}, {63'd0, exp_wr});
        chk({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
        tick();
        chk({tag, "_pulse"}, {63'd0, bus.div_valid}, 64'd0);
    endtask

    initial begin
        int bad;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.is_flush   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_opcode  = 10'd0;
        bus.in_funct7  = 7'd0;
        bus.in_rd      = 5'd0;
        bus.in_pc      = 32'd0;
        bus.in_rs1_val = 64'd0;
        bus.in_rs2_val = 64'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("rst_fwd",   {63'd0, bus.fwd_valid}, 64'd0);
        chk("rst_div",   {63'd0, bus.div_valid}, 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {63'd0, bus.in_ready}, 64'd1);

        // ADDI forwarded for exactly one cycle
        issue(10'h013, 7'h00, 5'd3, 64'd5, 64'd0);
        chk("addi_fwd",    {63'd0, bus.fwd_valid}, 64'd1);
        chk("addi_rs1",    bus.fwd_rs1_val, 64'd5);
        chk("addi_rd",     {59'd0, bus.fwd_rd}, 64'd3);
        chk("addi_opc",    {54'd0, bus.fwd_opcode}, 64'h013);
        chk("addi_pc",     {32'd0, bus.fwd_pc}, 64'h1003);
        chk("addi_ready",  {63'd0, bus.in_ready}, 64'd1);
        tick();
        chk("addi_pulse",  {63'd0, bus.fwd_valid}, 64'd0);

        // Back-to-back single-cycle accepts
        bus.in_valid = 1'b1; bus.in_opcode = 10'h033; bus.in_funct7 = 7'h00;
        bus.in_rd = 5'd4; bus.in_rs1_val = 64'd10; bus.in_rs2_val = 64'd20;
        tick();
        chk("b2b_fwd0", {63'd0, bus.fwd_valid}, 64'd1);
        chk("b2b_rs2_0", bus.fwd_rs2_val, 64'd20);
        bus.in_rs2_val = 64'd30;
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_fwd1", {63'd0, bus.fwd_valid}, 64'd1);
        chk("b2b_rs2_1", bus.fwd_rs2_val, 64'd30);
        tick();

        // Iterative divides
        run_div("div",   10'h233, 5'd7, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 66, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        run_div("rem",   10'h333, 5'd7, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 66, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        run_div("remu",  10'h3b3, 5'd9, 64'd100, 64'd7, 66, 64'd2, 1'b1);
        run_div("remw",  10'h33b, 5'd0, 64'd17, 64'd5, 34, 64'd2, 1'b0);
        run_div("divw",  10'h23b, 5'd2, 64'h0000_0000_FFFF_FFF9, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

        // Corner cases bypass RUN
        run_div("divuw0", 10'h2bb, 5'd5, 64'hFFFF_FFFF_0000_0010, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_div("divovf", 10'h233, 5'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'h8000_0000_0000_0000, 1'b1);
        run_div("removf", 10'h333, 5'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'd0, 1'b1);

        // Flush during a DIVU kills it
        issue(10'h2b3, 7'h01, 5'd8, 64'd1000, 64'd7);
        repeat (8) tick();
        chk("flush_busy_before", {63'd0, bus.busy}, 64'd1);
        bus.is_flush = 1'b1;
        tick();
        bus.is_flush = 1'b0;
        chk("flush_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("flush_busy",  {63'd0, bus.busy}, 64'd0);
        issue(10'h033, 7'h00, 5'd11, 64'd11, 64'd22);
        chk("flush_add_fwd", {63'd0, bus.fwd_valid}, 64'd1);
        chk("flush_add_rs2", bus.fwd_rs2_val, 64'd22);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.div_valid !== 1'b0) bad++;
            tick();
        end
        chk("flush_no_div", 64'(bad), 64'd0);

        // Flush in the same cycle as in_valid blocks the accept
        bus.is_flush = 1'b1;
        issue(10'h033, 7'h00, 5'd12, 64'd1, 64'd2);
        bus.is_flush = 1'b0;
        chk("flush_block_fwd", {63'd0, bus.fwd_valid}, 64'd0);
        chk("flush_block_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.is_flush = 1'b1;
        issue(10'h233, 7'h01, 5'd12, 64'd9, 64'd3);
        bus.is_flush = 1'b0;
        chk("flush_block_div_busy", {63'd0, bus.busy}, 64'd0);

        // Reset in the middle of RUN
        issue(10'h233, 7'h01, 5'd13, 64'd500, 64'd4);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("mrst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("mrst_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("mrst_data",  bus.div_data, 64'd0);
        reset = 1'b0;
        tick();
        chk("mrst_ready_after", {63'd0, bus.in_ready}, 64'd1);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.div_valid !== 1'b0) bad++;
            tick();
        end
        chk("mrst_no_div", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
